mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Arbitrates the CPU's instruction-fetch and data-access requests onto the single shared Avalon-style memory bus and sequences each bus transaction. It sits between the CPU datapath and top-level memory. It generates the `stall_o` that holds the multicycle `fsm` in its current state until the memory access completes.

## Interface
- `ADDR_W`, default 32: byte address width.
- `DATA_W`, default 32: data width; byte-enable width is `DATA_W/8`.

- `clk` in 1: single clock, posedge.
- `reset_i` in 1: asynchronous, active-high reset.
- `i_req_i` in 1: instruction-fetch request (read only), level.
- `i_addr_i` in ADDR_W: fetch address.
- `i_ack_o` out 1: one-cycle pulse, fetch complete.
- `d_req_i` in 1: data request, level.
- `d_we_i` in 1: 1 = write, 0 = read.
- `d_addr_i` in ADDR_W: data address.
- `d_wdata_i` in DATA_W: write data.
- `d_be_i` in DATA_W/8: byte enables.
- `d_ack_o` out 1: one-cycle pulse, data access complete.
- `rdata_o` out DATA_W: read data. Valid while either ack is high; holds its last value otherwise.
- `stall_o` out 1: `(i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o)`. Combinational.
- `avm_address_o` out ADDR_W, `avm_read_o` out 1, `avm_write_o` out 1, `avm_writedata_o` out DATA_W, `avm_byteenable_o` out DATA_W/8: bus command.
- `avm_readdata_i` in DATA_W, `avm_waitrequest_i` in 1: bus response.

## Operation
- States (`arb_state_t`):
  - `ARB_IDLE`
  - `ARB_BUS`: command driven, waiting for acceptance.
  - `ARB_RLAT`: read-latency cycle.
  - `ARB_DONE`: ack cycle.
- `ARB_IDLE`:
  - If any request is high, grant one.
  - Latch the command into registers: address, we, wdata, be, and grant id. Instruction fetches latch we=0 and be=all-ones.
  - Go to `ARB_BUS`.
- Arbitration:
  - A single requester wins outright.
  - If both request in the same cycle, the requester not granted last wins.
  - `last_grant` updates on every grant.
- `ARB_BUS`:
  - Drive `avm_read_o`/`avm_write_o` per the latched `we`, with address, writedata and byteenable from the latched command.
  - Hold all of these stable while `avm_waitrequest_i`=1. An indefinite waitrequest stays in `ARB_BUS` with stall asserted.
  - When `avm_waitrequest_i`=0, go to `ARB_RLAT` for a read or `ARB_DONE` for a write.
- `ARB_RLAT`: capture `avm_readdata_i` into `rdata_o`, then go to `ARB_DONE`.
- `ARB_DONE`: pulse the granted requester's ack for exactly one cycle, then go to `ARB_IDLE`.
- Requester contract:
  - Hold req and all command fields until ack.
  - Deassert req in the cycle after ack; the `fsm` advances on that edge. `stall_o` is already low during the ack cycle.
  - Command-field changes after grant are ignored, because the command is latched.
- Requests arriving while not in `ARB_IDLE` wait. The other requester's pending req is granted on the next `ARB_IDLE`.
- `avm_read_o` and `avm_write_o` are never both high. Both are 0 outside `ARB_BUS`.
- `avm_address_o` and the other data fields may show latched values outside `ARB_BUS`; memory ignores them.

## Timing
- Reset values: state `ARB_IDLE`, all `avm_*` outputs 0, both acks 0, `rdata_o` 0.
- `last_grant` resets to INSTR, so data wins the first tie.
- Reset asserted mid-transaction aborts immediately and asynchronously: `avm_read_o`/`avm_write_o` drop without waiting for a clock. No ack is issued.
- Read, zero waitstates (request first seen in `ARB_IDLE` at cycle 0):
  - Cycle 1: `avm_read_o`=1.
  - Cycle 2: `ARB_RLAT`, readdata sampled at the end of the cycle.
  - Cycle 3: ack=1, `rdata_o` valid.
  - Cycle 4: `ARB_IDLE`.
  - Each waitrequest cycle adds 1.
- Write, zero waitstates:
  - Cycle 1: `avm_write_o`=1.
  - Cycle 2: ack.
  - Cycle 3: `ARB_IDLE`.
- Minimum request-to-request spacing is one `ARB_IDLE` cycle after each `ARB_DONE`.

## Structure
- Add `arb_state_t` and `grant_t` (`GNT_INSTR`, `GNT_DATA`) to the shared `codes` package, alongside `state_t`.
- One file with one `always_ff` for state, command registers and `last_grant` (async reset). A single `always_comb` holds next-state logic and outputs.
- No sub-module is needed. The tie-break could be split into `rr_pick` (2-input round-robin, combinational), but inline is preferred.

## Test plan
- Fetch from 0xBFC00000, waitrequest 0, memory returns 0x24020005 → `avm_read_o` high for one cycle, `i_ack_o` in cycle 3, `rdata_o`=0x24020005, `stall_o` high for cycles 0–2.
- Data write 0x10 with wdata 0xDEADBEEF, be=4'b0011, waitrequest high for 3 cycles → address, data and byteenable held stable for 4 bus cycles, `d_ack_o` 1 cycle after acceptance, `avm_read_o` never high.
- `i_req_i` and `d_req_i` rise together from reset → data granted first; fetch granted on the next `ARB_IDLE`. On a second tie, fetch wins.
- Fetch request raised while a data read is in `ARB_BUS` → no bus change until `d_ack_o`, then fetch is issued after one `ARB_IDLE` cycle.
- `reset_i` pulsed during `ARB_BUS` of a write → `avm_write_o` falls before the next edge, no ack, `ARB_IDLE` after release.
- `i_addr_i` changed after grant → bus address keeps the originally latched value.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the CPU memory arbiter: bus sequencing states, grant ids
// and the two-way round-robin tie-break.
package mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUS  = 2'd1,
        ARB_RLAT = 2'd2,
        ARB_DONE = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_INSTR = 1'b0,
        GNT_DATA  = 1'b1
    } grant_t;

    // On a tie the requester that was not served last wins.
    function automatic grant_t rr_pick(input logic i_req, input logic d_req,
                                       input grant_t last);
        grant_t pick;
        if (i_req && d_req) begin
            if (last == GNT_INSTR) pick = GNT_DATA;
            else                   pick = GNT_INSTR;
        end else if (d_req) begin
            pick = GNT_DATA;
        end else begin
            pick = GNT_INSTR;
        end
        return pick;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data access onto one Avalon-style bus,
// sequences each transaction and produces the CPU stall.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                reset_i,
    input  logic                i_req_i,
    input  logic [ADDR_W-1:0]   i_addr_i,
    output logic                i_ack_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [ADDR_W-1:0]   d_addr_i,
    input  logic [DATA_W-1:0]   d_wdata_i,
    input  logic [DATA_W/8-1:0] d_be_i,
    output logic                d_ack_o,
    output logic [DATA_W-1:0]   rdata_o,
    output logic                stall_o,
    output logic [ADDR_W-1:0]   avm_address_o,
    output logic                avm_read_o,
    output logic                avm_write_o,
    output logic [DATA_W-1:0]   avm_writedata_o,
    output logic [DATA_W/8-1:0] avm_byteenable_o,
    input  logic [DATA_W-1:0]   avm_readdata_i,
    input  logic                avm_waitrequest_i
);

    localparam int BE_W = DATA_W / 8;

    arb_state_t          state_q, state_d;
    grant_t              gnt_q, last_q, pick_d;
    logic                grant_en_d;
    logic [ADDR_W-1:0]   addr_q;
    logic                we_q;
    logic [DATA_W-1:0]   wdata_q;
    logic [BE_W-1:0]     be_q;
    logic [DATA_W-1:0]   rdata_q;

    always_comb begin
        state_d     = state_q;
        pick_d      = rr_pick(i_req_i, d_req_i, last_q);
        grant_en_d  = 1'b0;
        avm_read_o  = 1'b0;
        avm_write_o = 1'b0;
        i_ack_o     = 1'b0;
        d_ack_o     = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (i_req_i || d_req_i) begin
                    grant_en_d = 1'b1;
                    state_d    = ARB_BUS;
                end
            end
            ARB_BUS: begin
                avm_read_o  = ~we_q;
                avm_write_o = we_q;
                if (!avm_waitrequest_i) state_d = we_q ? ARB_DONE : ARB_RLAT;
            end
            ARB_RLAT: state_d = ARB_DONE;
            ARB_DONE: begin
                i_ack_o = (gnt_q == GNT_INSTR);
                d_ack_o = (gnt_q == GNT_DATA);
                state_d = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    // The ack cycle already releases the stall so the fsm advances on its edge.
    assign stall_o          = (i_req_i & ~i_ack_o) | (d_req_i & ~d_ack_o);
    assign avm_address_o    = addr_q;
    assign avm_writedata_o  = wdata_q;
    assign avm_byteenable_o = be_q;
    assign rdata_o          = rdata_q;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ARB_IDLE;
            gnt_q   <= GNT_INSTR;
            last_q  <= GNT_INSTR;
            addr_q  <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (grant_en_d) begin
                gnt_q  <= pick_d;
                last_q <= pick_d;
                if (pick_d == GNT_DATA) begin
                    addr_q  <= d_addr_i;
                    we_q    <= d_we_i;
                    wdata_q <= d_wdata_i;
                    be_q    <= d_be_i;
                end else begin
                    addr_q  <= i_addr_i;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                    be_q    <= '1;
                end
            end
            if (state_q == ARB_RLAT) rdata_q <= avm_readdata_i;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table-driven transactions with a
// scoreboard, plus hand-written tie-break, overlap and reset sequences.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        i_req_i;
    logic [31:0] i_addr_i;
    logic        i_ack_o;
    logic        d_req_i;
    logic        d_we_i;
    logic [31:0] d_addr_i;
    logic [31:0] d_wdata_i;
    logic [3:0]  d_be_i;
    logic        d_ack_o;
    logic [31:0] rdata_o;
    logic        stall_o;
    logic [31:0] avm_address_o;
    logic        avm_read_o;
    logic        avm_write_o;
    logic [31:0] avm_writedata_o;
    logic [3:0]  avm_byteenable_o;
    logic [31:0] avm_readdata_i;
    logic        avm_waitrequest_i;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk              (clk),
        .reset_i          (reset_i),
        .i_req_i          (i_req_i),
        .i_addr_i         (i_addr_i),
        .i_ack_o          (i_ack_o),
        .d_req_i          (d_req_i),
        .d_we_i           (d_we_i),
        .d_addr_i         (d_addr_i),
        .d_wdata_i        (d_wdata_i),
        .d_be_i           (d_be_i),
        .d_ack_o          (d_ack_o),
        .rdata_o          (rdata_o),
        .stall_o          (stall_o),
        .avm_address_o    (avm_address_o),
        .avm_read_o       (avm_read_o),
        .avm_write_o      (avm_write_o),
        .avm_writedata_o  (avm_writedata_o),
        .avm_byteenable_o (avm_byteenable_o),
        .avm_readdata_i   (avm_readdata_i),
        .avm_waitrequest_i(avm_waitrequest_i)
    );

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          waits;
        logic [31:0] rdat;
    } vec_t;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [31:0] rdat;
        int          lat;
    } exp_t;

    exp_t        sb[$];
    vec_t        vt[6];
    int          n_chk  = 0;
    int          n_pass = 0;
    logic [31:0] last_rd = 32'h0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps until an ack appears (bounded), then checks which one it was.
    task automatic wait_ack(input logic want_data, input string nm);
        int k;
        k = 0;
        while (!(i_ack_o || d_ack_o) && k < 40) begin
            step();
            k++;
        end
        check({nm, "_ack"},   want_data ? d_ack_o : i_ack_o, 32'd1);
        check({nm, "_other"}, want_data ? i_ack_o : d_ack_o, 32'd0);
    endtask

    task automatic run_txn(input vec_t v, input string nm);
        exp_t        e;
        exp_t        got;
        int          cyc;
        int          bus;
        logic        done;
        logic [3:0]  exp_be;
        e.is_data = v.is_data;
        e.we      = v.is_data & v.we;
        e.rdat    = v.rdat;
        e.lat     = v.waits + (e.we ? 2 : 3);
        sb.push_back(e);
        exp_be = v.is_data ? v.be : 4'hF;
        avm_readdata_i    = v.rdat;
        avm_waitrequest_i = 1'b1;
        if (v.is_data) begin
            d_req_i = 1'b1; d_we_i = v.we; d_addr_i = v.addr;
            d_wdata_i = v.wdata; d_be_i = v.be;
        end else begin
            i_req_i = 1'b1; i_addr_i = v.addr;
        end
        #1 check({nm, "_stall_c0"}, stall_o, 32'd1);
        cyc = 0; bus = 0; done = 1'b0;
        while (!done && cyc < 64) begin
            step();
            cyc++;
            if (avm_read_o || avm_write_o) begin
                bus++;
                check({nm, "_addr"},  avm_address_o, v.addr);
                check({nm, "_write"}, avm_write_o, e.we);
                check({nm, "_read"},  avm_read_o, !e.we);
                check({nm, "_be"},    avm_byteenable_o, exp_be);
                if (e.we) check({nm, "_wdata"}, avm_writedata_o, v.wdata);
                avm_waitrequest_i = (bus <= v.waits);
            end
            if (i_ack_o || d_ack_o) begin
                done = 1'b1;
                if (sb.size() == 0) begin
                    check({nm, "_sb_empty"}, 32'd0, 32'd1);
                end else begin
                    got = sb.pop_front();
                    check({nm, "_ack"},   got.is_data ? d_ack_o : i_ack_o, 32'd1);
                    check({nm, "_other"}, got.is_data ? i_ack_o : d_ack_o, 32'd0);
                    check({nm, "_lat"},   cyc, got.lat);
                    check({nm, "_rdata"}, rdata_o, got.we ? last_rd : got.rdat);
                    if (!got.we) last_rd = got.rdat;
                end
                check({nm, "_stall_ack"}, stall_o, 32'd0);
            end else begin
                check({nm, "_stall_busy"}, stall_o, 32'd1);
            end
        end
        if (!done) begin
            check({nm, "_timeout"}, 32'd0, 32'd1);
            sb.delete();
        end
        check({nm, "_buscyc"}, bus, v.waits + 1);
        step();
        i_req_i = 1'b0;
        d_req_i = 1'b0;
        #1;
        check({nm, "_ackdrop"}, {30'd0, i_ack_o, d_ack_o}, 32'd0);
        check({nm, "_idle_bus"}, {30'd0, avm_read_o, avm_write_o}, 32'd0);
        check({nm, "_rhold"}, rdata_o, last_rd);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vt[0] = '{1'b0, 1'b0, 32'hBFC0_0000, 32'h0,         4'hF,    0, 32'h2402_0005};
        vt[1] = '{1'b1, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'b0011, 3, 32'h0};
        vt[2] = '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'b1100, 1, 32'hCAFE_F00D};
        vt[3] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,         4'hF,    2, 32'hFFFF_FFFF};
        vt[4] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0,         4'b1000, 0, 32'h0};
        vt[5] = '{1'b1, 1'b0, 32'h0000_0008, 32'h0,         4'hF,    0, 32'h0};

        reset_i = 1'b1;
        i_req_i = 0; i_addr_i = 0; d_req_i = 0; d_we_i = 0;
        d_addr_i = 0; d_wdata_i = 0; d_be_i = 0;
        avm_readdata_i = 0; avm_waitrequest_i = 0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_read",  avm_read_o, 32'd0);
        check("rst_write", avm_write_o, 32'd0);
        check("rst_addr",  avm_address_o, 32'd0);
        check("rst_wdata", avm_writedata_o, 32'd0);
        check("rst_be",    avm_byteenable_o, 32'd0);
        check("rst_acks",  {30'd0, i_ack_o, d_ack_o}, 32'd0);
        check("rst_rdata", rdata_o, 32'd0);
        check("rst_stall", stall_o, 32'd0);
        reset_i = 1'b0;
        step();

        // First tie after reset: data wins, fetch follows on the next idle.
        i_req_i = 1; i_addr_i = 32'h0000_1000;
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h0000_2000; d_be_i = 4'hF;
        avm_readdata_i = 32'h1111_2222;
        step();
        check("tie1_addr", avm_address_o, 32'h0000_2000);
        check("tie1_read", avm_read_o, 32'd1);
        wait_ack(1'b1, "tie1_d");
        check("tie1_drdata", rdata_o, 32'h1111_2222);
        step();
        d_req_i = 0;
        #1 check("tie1_gap", {30'd0, avm_read_o, avm_write_o}, 32'd0);
        avm_readdata_i = 32'h3333_4444;
        step();
        check("tie1_faddr", avm_address_o, 32'h0000_1000);
        check("tie1_fread", avm_read_o, 32'd1);
        wait_ack(1'b0, "tie1_i");
        check("tie1_irdata", rdata_o, 32'h3333_4444);
        last_rd = 32'h3333_4444;
        step();
        i_req_i = 0;
        step();

        run_txn('{1'b1, 1'b1, 32'h40, 32'hA5A5_A5A5, 4'hF, 0, 32'h0}, "dwr");

        // Second tie: data was served last, so fetch wins.
        i_req_i = 1; i_addr_i = 32'h0000_1004;
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h44; d_wdata_i = 32'h5A5A_5A5A; d_be_i = 4'hF;
        avm_readdata_i = 32'h5555_6666;
        step();
        check("tie2_addr",  avm_address_o, 32'h0000_1004);
        check("tie2_read",  avm_read_o, 32'd1);
        check("tie2_write", avm_write_o, 32'd0);
        wait_ack(1'b0, "tie2_i");
        last_rd = 32'h5555_6666;
        step();
        i_req_i = 0;
        step();
        check("tie2_daddr",  avm_address_o, 32'h44);
        check("tie2_dwrite", avm_write_o, 32'd1);
        wait_ack(1'b1, "tie2_d");
        step();
        d_req_i = 0;
        step();

        for (int i = 0; i < 6; i++) run_txn(vt[i], $sformatf("vec%0d", i));

        // Fetch arriving while a data read is on the bus waits its turn.
        d_req_i = 1; d_we_i = 0; d_addr_i = 32'h300; d_be_i = 4'hF;
        avm_waitrequest_i = 1; avm_readdata_i = 32'h7777_8888;
        step();
        i_req_i = 1; i_addr_i = 32'h500;
        step();
        check("ovl_addr", avm_address_o, 32'h300);
        check("ovl_read", avm_read_o, 32'd1);
        avm_waitrequest_i = 0;
        step();
        check("ovl_rlat_iack", i_ack_o, 32'd0);
        wait_ack(1'b1, "ovl_d");
        check("ovl_rdata", rdata_o, 32'h7777_8888);
        check("ovl_addr_hold", avm_address_o, 32'h300);
        step();
        d_req_i = 0;
        #1 check("ovl_gap", {30'd0, avm_read_o, avm_write_o}, 32'd0);
        avm_readdata_i = 32'h0BAD_CAFE;
        step();
        check("ovl_faddr", avm_address_o, 32'h500);
        check("ovl_fread", avm_read_o, 32'd1);
        wait_ack(1'b0, "ovl_i");
        check("ovl_frdata", rdata_o, 32'h0BAD_CAFE);
        last_rd = 32'h0BAD_CAFE;
        step();
        i_req_i = 0;
        step();

        // Reset pulse mid-write drops the strobe without a clock edge.
        d_req_i = 1; d_we_i = 1; d_addr_i = 32'h600; d_wdata_i = 32'h1234_5678; d_be_i = 4'hF;
        avm_waitrequest_i = 1;
        step();
        check("rstw_write", avm_write_o, 32'd1);
        #2 reset_i = 1;
        #1;
        check("rstw_async_write", avm_write_o, 32'd0);
        check("rstw_async_read",  avm_read_o, 32'd0);
        check("rstw_async_ack",   {30'd0, i_ack_o, d_ack_o}, 32'd0);
        d_req_i = 0;
        avm_waitrequest_i = 0;
        step();
        reset_i = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("rstw_noack", {30'd0, i_ack_o, d_ack_o}, 32'd0);
            check("rstw_nobus", {30'd0, avm_read_o, avm_write_o}, 32'd0);
        end
        last_rd = 32'h0;

        // Command changes after grant are ignored.
        i_req_i = 1; i_addr_i = 32'h700;
        avm_waitrequest_i = 1; avm_readdata_i = 32'h9999_0000;
        step();
        check("lat_addr0", avm_address_o, 32'h700);
        i_addr_i = 32'h7FC;
        step();
        check("lat_addr1", avm_address_o, 32'h700);
        check("lat_read",  avm_read_o, 32'd1);
        avm_waitrequest_i = 0;
        step();
        wait_ack(1'b0, "lat_i");
        check("lat_rdata", rdata_o, 32'h9999_0000);
        step();
        i_req_i = 0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
